// File: rtl/stone_plotter.sv
// Stone-drawing sequencer: turns a 7x7 board-cell draw request into a 15x15 disc,
// one pixel per clock on the VGA adapter's x/y/colour/plot port.
module stone_plotter #(
    parameter int unsigned ORIGIN_X = 24,
    parameter int unsigned ORIGIN_Y = 4,
    parameter int unsigned PITCH    = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       req,
    input  logic [2:0] req_x,
    input  logic [2:0] req_y,
    input  logic [2:0] req_colour,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot
);

    localparam int unsigned XW   = 8;
    localparam int unsigned YW   = 7;
    localparam int unsigned CW   = 3;
    localparam int unsigned PW   = 4;
    localparam int unsigned LAST = 14;

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   base_x_q, base_x_d;
    logic [YW-1:0]   base_y_q, base_y_d;
    logic [CW-1:0]   col_q, col_d;
    logic [PW-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic            err_pend_q, err_pend_d;
    logic            busy_d, done_d, err_d, plot_d;
    logic [XW-1:0]   vga_x_d;
    logic [YW-1:0]   vga_y_d;
    logic [CW-1:0]   vga_colour_d;
    logic [PW-1:0]   lo;
    logic [PW-1:0]   hi;

    // Leftmost lit column of each disc row; the disc is mirror-symmetric.
    function automatic logic [PW-1:0] row_lo(input logic [PW-1:0] r);
        case (r)
            4'd0, 4'd14:               row_lo = 4'd5;
            4'd1, 4'd13:               row_lo = 4'd3;
            4'd2, 4'd12:               row_lo = 4'd2;
            4'd3, 4'd4, 4'd10, 4'd11:  row_lo = 4'd1;
            default:                   row_lo = 4'd0;
        endcase
    endfunction

    assign lo = row_lo(cy_q);
    assign hi = PW'(LAST) - lo;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            base_x_q   <= '0;
            base_y_q   <= '0;
            col_q      <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            err_pend_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            plot       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            state_q    <= state_d;
            base_x_q   <= base_x_d;
            base_y_q   <= base_y_d;
            col_q      <= col_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            err_pend_q <= err_pend_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            plot       <= plot_d;
            vga_x      <= vga_x_d;
            vga_y      <= vga_y_d;
            vga_colour <= vga_colour_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_x_d     = base_x_q;
        base_y_d     = base_y_q;
        col_d        = col_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        err_pend_d   = 1'b0;
        busy_d       = (state_q != IDLE);
        done_d       = 1'b0;
        err_d        = err_pend_q;
        plot_d       = 1'b0;
        vga_x_d      = vga_x;
        vga_y_d      = vga_y;
        vga_colour_d = vga_colour;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (req_x <= 3'd6 && req_y <= 3'd6) begin
                        base_x_d = XW'(ORIGIN_X + PITCH * 32'(req_x));
                        base_y_d = YW'(ORIGIN_Y + PITCH * 32'(req_y));
                        col_d    = req_colour;
                        cx_d     = '0;
                        cy_d     = '0;
                        state_d  = DRAW;
                    end else begin
                        // Rejection is reported with the same latency as the first pixel.
                        err_pend_d = 1'b1;
                    end
                end
            end
            DRAW: begin
                vga_x_d      = base_x_q + XW'(cx_q);
                vga_y_d      = base_y_q + YW'(cy_q);
                vga_colour_d = col_q;
                plot_d       = (cx_q >= lo) && (cx_q <= hi);
                if (cx_q == PW'(LAST)) begin
                    cx_d = '0;
                    if (cy_q == PW'(LAST)) begin
                        state_d = DONE;
                    end else begin
                        cy_d = cy_q + PW'(1);
                    end
                end else begin
                    cx_d = cx_q + PW'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stone_plotter.sv
// Directed bench for stone_plotter: table of stone requests with hand-computed
// pixel geometry, plus sequences for rejection and mid-draw reset.
module tb_stone_plotter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       req;
    logic [2:0] req_x, req_y, req_colour;
    logic       busy, done, err, plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int x, y, col, inject;
        int p0x, p0y, plx, ply;
        int fx, fy, lx, ly;
        int minx, maxx, miny, maxy;
    } vec_t;

    vec_t vecs[5];
    vec_t after_rst;

    stone_plotter dut (
        .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .busy(busy), .done(done), .err(err),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_stone(input vec_t v);
        int plots = 0, dones = 0, errs = 0, colbad = 0;
        int done_at = -1, fall_at = -1, busy1 = 0, plp = 1;
        int fx = -1, fy = -1, lx = -1, ly = -1;
        int minx = 999, maxx = -1, miny = 999, maxy = -1;
        int p0x = -1, p0y = -1, plx = -1, ply = -1;
        @(negedge clk);
        req = 1'b1; req_x = 3'(v.x); req_y = 3'(v.y); req_colour = 3'(v.col);
        @(posedge clk); #1;
        req = 1'b0;
        for (int k = 1; k <= 228; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin p0x = int'(vga_x); p0y = int'(vga_y); busy1 = int'(busy); end
            if (k == 225) begin plx = int'(vga_x); ply = int'(vga_y); plp = int'(plot); end
            if (plot) begin
                plots++;
                if (fx < 0) begin fx = int'(vga_x); fy = int'(vga_y); end
                lx = int'(vga_x); ly = int'(vga_y);
                if (int'(vga_x) < minx) minx = int'(vga_x);
                if (int'(vga_x) > maxx) maxx = int'(vga_x);
                if (int'(vga_y) < miny) miny = int'(vga_y);
                if (int'(vga_y) > maxy) maxy = int'(vga_y);
                if (int'(vga_colour) != v.col) colbad++;
            end
            if (done) begin dones++; if (done_at < 0) done_at = k; end
            if (err) errs++;
            if (!busy && k > 1 && fall_at < 0) fall_at = k;
            if (v.inject != 0) begin
                if (k == 99) begin req = 1'b1; req_x = 3'd5; req_y = 3'd1; req_colour = 3'd0; end
                else if (k == 100) req = 1'b0;
            end
        end
        chk("busy_first_pixel", busy1, 1);
        chk("first_px_x", p0x, v.p0x);
        chk("first_px_y", p0y, v.p0y);
        chk("last_px_x", plx, v.plx);
        chk("last_px_y", ply, v.ply);
        chk("last_px_plot", plp, 0);
        chk("plot_count", plots, 177);
        chk("first_plot_x", fx, v.fx);
        chk("first_plot_y", fy, v.fy);
        chk("last_plot_x", lx, v.lx);
        chk("last_plot_y", ly, v.ly);
        chk("min_plot_x", minx, v.minx);
        chk("max_plot_x", maxx, v.maxx);
        chk("min_plot_y", miny, v.miny);
        chk("max_plot_y", maxy, v.maxy);
        chk("plot_colour_errors", colbad, 0);
        chk("done_pulses", dones, 1);
        chk("done_cycle", done_at, 226);
        chk("busy_fall_cycle", fall_at, 227);
        chk("err_during_stone", errs, 0);
    endtask

    task automatic run_invalid(input int x, input int y);
        @(negedge clk);
        req = 1'b1; req_x = 3'(x); req_y = 3'(y); req_colour = 3'd7;
        @(posedge clk); #1;
        req = 1'b0;
        chk("inv_err_e0", int'(err), 0);
        chk("inv_busy_e0", int'(busy), 0);
        @(posedge clk); #1;
        chk("inv_err_e1", int'(err), 1);
        chk("inv_busy_e1", int'(busy), 0);
        chk("inv_plot_e1", int'(plot), 0);
        @(posedge clk); #1;
        chk("inv_err_e2", int'(err), 0);
        chk("inv_busy_e2", int'(busy), 0);
        chk("inv_done_e2", int'(done), 0);
    endtask

    initial begin
        int seen;
        resetn = 1'b0; req = 1'b0; req_x = '0; req_y = '0; req_colour = '0;
        vecs[0] = '{3, 3, 7, 0,  72,  52,  86,  66,  77,  52,  81,  66,  72,  86,  52,  66};
        vecs[1] = '{0, 0, 0, 0,  24,   4,  38,  18,  29,   4,  33,  18,  24,  38,   4,  18};
        vecs[2] = '{6, 6, 0, 0, 120, 100, 134, 114, 125, 100, 129, 114, 120, 134, 100, 114};
        vecs[3] = '{2, 2, 7, 1,  56,  36,  70,  50,  61,  36,  65,  50,  56,  70,  36,  50};
        vecs[4] = '{5, 1, 0, 0, 104,  20, 118,  34, 109,  20, 113,  34, 104, 118,  20,  34};
        after_rst = '{1, 1, 7, 0, 40, 20, 54, 34, 45, 20, 49, 34, 40, 54, 20, 34};

        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_vga_x", int'(vga_x), 0);
        chk("rst_vga_y", int'(vga_y), 0);
        chk("rst_vga_colour", int'(vga_colour), 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 5; i++) run_stone(vecs[i]);

        run_invalid(7, 3);
        run_invalid(3, 7);

        // Asynchronous reset in the middle of a stone.
        @(negedge clk);
        req = 1'b1; req_x = 3'd4; req_y = 3'd2; req_colour = 3'd7;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_vga_x", int'(vga_x), 102);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_plot", int'(plot), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_vga_x", int'(vga_x), 0);
        chk("async_rst_vga_y", int'(vga_y), 0);
        chk("async_rst_colour", int'(vga_colour), 0);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (done || busy || plot) seen++;
        end
        chk("held_rst_quiet", seen, 0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 240; k++) begin
            @(posedge clk); #1;
            if (done || busy || plot) seen++;
        end
        chk("post_rst_quiet", seen, 0);
        run_stone(after_rst);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
